// File: rtl/rvc_muldiv.sv
// RV32/64 M-extension multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Normal ops take XLEN+3 cycles, div-by-zero/overflow 1 cycle; result held until OutReady.
module rvc_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Kill,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [2:0] {IDLE, PREP, BUSY, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opa, opb, result;
  logic [2*XLEN-1:0]   prod;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q, neg_r;

  logic                accept, div0, ovf, special;
  logic [XLEN-1:0]     special_res;
  logic                sa, sb;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN:0]       msum, dpart, dsub;
  logic                qbit;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, pm;
  logic [XLEN-1:0]     q_raw, r_raw, fix_res;

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign Result   = result;
  assign accept   = InValid && InReady;

  // Special divide cases bypass the iterative datapath entirely.
  assign div0    = Op[2] && (SrcB == '0);
  assign ovf     = ((Op == 3'd4) || (Op == 3'd6)) &&
                   (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (&SrcB);
  assign special = div0 || ovf;

  always_comb begin
    special_res = '1;
    if (div0)
      special_res = Op[1] ? SrcA : '1;
    else if (ovf)
      special_res = Op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    sa    = ((op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6)) && opa[XLEN-1];
    sb    = ((op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6)) && opb[XLEN-1];
    abs_a = sa ? -opa : opa;
    abs_b = sb ? -opb : opb;
  end

  // prod = {hi, lo}: multiply accumulates into hi and shifts right;
  // divide keeps the partial remainder in hi and the dividend/quotient in lo.
  always_comb begin
    msum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opa} : {(XLEN+1){1'b0}});
    mul_nxt = {msum, prod[XLEN-1:1]};
    dpart   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    dsub    = dpart - {1'b0, opb};
    qbit    = ~dsub[XLEN];
    div_nxt = {(qbit ? dsub[XLEN-1:0] : dpart[XLEN-1:0]), prod[XLEN-2:0], qbit};
  end

  always_comb begin
    pm    = neg_q ? -prod : prod;
    q_raw = prod[XLEN-1:0];
    r_raw = prod[2*XLEN-1:XLEN];
    if (op_q[2])
      fix_res = op_q[1] ? (neg_r ? -r_raw : r_raw) : (neg_q ? -q_raw : q_raw);
    else
      fix_res = (op_q[1:0] == 2'd0) ? pm[XLEN-1:0] : pm[2*XLEN-1:XLEN];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : PREP;
      PREP: state_nxt = BUSY;
      BUSY: if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (OutReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Kill) state_nxt = IDLE;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      prod   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (!Kill) begin
      case (state)
        IDLE: if (accept) begin
          op_q <= Op;
          opa  <= SrcA;
          opb  <= SrcB;
          if (special) result <= special_res;
        end
        PREP: begin
          opa   <= abs_a;
          opb   <= abs_b;
          prod  <= {{XLEN{1'b0}}, (op_q[2] ? abs_a : abs_b)};
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt   <= '0;
        end
        BUSY: begin
          prod <= op_q[2] ? div_nxt : mul_nxt;
          cnt  <= cnt + CNT_W'(1);
        end
        FIX: result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
